// File: rtl/sr_cmd_debounce.sv
// rtl/sr_cmd_debounce.sv - synchronise, debounce and arbitrate set/reset buttons into clean s/r pulses
module sr_cmd_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_exp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [7:0] DB_LAST    = 8'(DB_CYCLES - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_LEN - 1);

    // Bit 0 carries the set path, bit 1 the reset path throughout.
    logic [1:0] btn;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] db;
    logic [1:0] db_n;
    logic [7:0] cnt   [2];
    logic [7:0] cnt_n [2];
    logic [1:0] rise;
    logic [1:0] pend;
    logic [1:0] pend_n;
    logic [1:0] clr;

    state_t     state;
    state_t     state_n;
    logic [3:0] pcnt;
    logic [3:0] pcnt_n;
    logic       s_n;
    logic       r_n;
    logic       conflict_n;
    logic       q_n;
    logic       busy_n;
    logic       dispatch;

    assign btn = {rst_btn, set_btn};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_n[i]  = db[i];
            cnt_n[i] = 8'd0;
            if (sync2[i] != db[i]) begin
                if (cnt[i] == DB_LAST) begin
                    db_n[i] = sync2[i];
                end else begin
                    cnt_n[i] = cnt[i] + 8'd1;
                end
            end
        end
        rise = db_n & ~db;
    end

    always_comb begin
        state_n    = state;
        pcnt_n     = pcnt;
        s_n        = 1'b0;
        r_n        = 1'b0;
        conflict_n = 1'b0;
        q_n        = q_exp;
        clr        = 2'b00;
        dispatch   = 1'b0;

        case (state)
            IDLE: dispatch = 1'b1;
            PULSE_S: begin
                if (pcnt == PULSE_LAST) begin
                    state_n = GAP;
                    pcnt_n  = 4'd0;
                end else begin
                    s_n    = 1'b1;
                    pcnt_n = pcnt + 4'd1;
                end
            end
            PULSE_R: begin
                if (pcnt == PULSE_LAST) begin
                    state_n = GAP;
                    pcnt_n  = 4'd0;
                end else begin
                    r_n    = 1'b1;
                    pcnt_n = pcnt + 4'd1;
                end
            end
            GAP: begin
                // The last gap cycle arbitrates like IDLE so back-to-back commands see exactly GAP_LEN low cycles.
                if (pcnt == GAP_LAST) begin
                    state_n  = IDLE;
                    dispatch = 1'b1;
                end else begin
                    pcnt_n = pcnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (dispatch) begin
            case (pend)
                2'b01: begin
                    state_n = PULSE_S;
                    pcnt_n  = 4'd0;
                    s_n     = 1'b1;
                    q_n     = 1'b1;
                    clr     = 2'b01;
                end
                2'b10: begin
                    state_n = PULSE_R;
                    pcnt_n  = 4'd0;
                    r_n     = 1'b1;
                    q_n     = 1'b0;
                    clr     = 2'b10;
                end
                2'b11: begin
                    state_n    = IDLE;
                    conflict_n = 1'b1;
                    clr        = 2'b11;
                end
                default: ;
            endcase
        end

        pend_n = (pend & ~clr) | rise;
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            db       <= 2'b00;
            cnt[0]   <= 8'd0;
            cnt[1]   <= 8'd0;
            pend     <= 2'b00;
            state    <= IDLE;
            pcnt     <= 4'd0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            q_exp    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            db       <= db_n;
            cnt[0]   <= cnt_n[0];
            cnt[1]   <= cnt_n[1];
            pend     <= pend_n;
            state    <= state_n;
            pcnt     <= pcnt_n;
            s        <= s_n;
            r        <= r_n;
            busy     <= busy_n;
            conflict <= conflict_n;
            q_exp    <= q_n;
        end
    end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// tb/tb_sr_cmd_debounce.sv - directed table and sequence checks for sr_cmd_debounce
module tb_sr_cmd_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic set_a, rst_a, s_a, r_a, busy_a, conf_a, q_a;
    logic set_b, rst_b, s_b, r_b, busy_b, conf_b, q_b;
    logic set_c, rst_c, s_c, r_c, busy_c, conf_c, q_c;

    sr_cmd_debounce u_a (
        .clk(clk), .rst_n(rst_n), .set_btn(set_a), .rst_btn(rst_a),
        .s(s_a), .r(r_a), .busy(busy_a), .conflict(conf_a), .q_exp(q_a)
    );

    sr_cmd_debounce #(.PULSE_LEN(2), .GAP_LEN(3)) u_b (
        .clk(clk), .rst_n(rst_n), .set_btn(set_b), .rst_btn(rst_b),
        .s(s_b), .r(r_b), .busy(busy_b), .conflict(conf_b), .q_exp(q_b)
    );

    sr_cmd_debounce #(.PULSE_LEN(4)) u_c (
        .clk(clk), .rst_n(rst_n), .set_btn(set_c), .rst_btn(rst_c),
        .s(s_c), .r(r_c), .busy(busy_c), .conflict(conf_c), .q_exp(q_c)
    );

    wire [4:0] out_a = {s_a, r_a, busy_a, conf_a, q_a};
    wire [4:0] out_b = {s_b, r_b, busy_b, conf_b, q_b};
    wire [4:0] out_c = {s_c, r_c, busy_c, conf_c, q_c};

    // Expected field order: {s, r, busy, conflict, q_exp}
    typedef struct {
        logic       set_v;
        logic       rst_v;
        int         n;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic sv, input logic rv, input int n, input logic [4:0] e);
        vec_t v;
        v.set_v = sv;
        v.rst_v = rv;
        v.n     = n;
        v.exp   = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (s r busy conflict q_exp)", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_a = 0; rst_a = 0; set_b = 0; rst_b = 0; set_c = 0; rst_c = 0;

        // Clean set: pulse seven edges after the press, busy for two cycles.
        tbl.push_back(mk(1, 0, 6,  5'b00000));
        tbl.push_back(mk(1, 0, 1,  5'b10101));
        tbl.push_back(mk(1, 0, 1,  5'b00101));
        tbl.push_back(mk(1, 0, 1,  5'b00001));
        tbl.push_back(mk(0, 0, 10, 5'b00001));
        // Three-cycle bounces on reset never survive the debouncer.
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, 1, 3, 5'b00001));
            tbl.push_back(mk(0, 0, 3, 5'b00001));
        end
        tbl.push_back(mk(0, 0, 4, 5'b00001));
        // Simultaneous press: one conflict pulse, q_exp held.
        tbl.push_back(mk(1, 1, 6,  5'b00001));
        tbl.push_back(mk(1, 1, 1,  5'b00011));
        tbl.push_back(mk(1, 1, 1,  5'b00001));
        tbl.push_back(mk(0, 0, 10, 5'b00001));
        // Clean reset command.
        tbl.push_back(mk(0, 1, 6,  5'b00001));
        tbl.push_back(mk(0, 1, 1,  5'b01100));
        tbl.push_back(mk(0, 1, 1,  5'b00100));
        tbl.push_back(mk(0, 0, 1,  5'b00000));
        tbl.push_back(mk(0, 0, 10, 5'b00000));

        #2;
        chk("reset_no_clock_a", out_a, 5'b00000);
        chk("reset_no_clock_b", out_b, 5'b00000);
        chk("reset_no_clock_c", out_c, 5'b00000);
        repeat (3) tick;
        chk("reset_held_a", out_a, 5'b00000);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            set_a = tbl[i].set_v;
            rst_a = tbl[i].rst_v;
            repeat (tbl[i].n) tick;
            chk($sformatf("table_row%0d", i), out_a, tbl[i].exp);
        end
        set_a = 0; rst_a = 0;

        // Back-to-back: set, then reset two cycles later; gap of exactly three.
        set_b = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            logic [4:0] e;
            tick;
            e[4] = (c == 7 || c == 8);
            e[3] = (c == 12 || c == 13);
            e[2] = (c >= 7 && c <= 16);
            e[1] = 1'b0;
            e[0] = (c >= 7 && c <= 11);
            chk($sformatf("b2b_c%0d", c), out_b, e);
            if (c == 2) rst_b = 1'b1;
        end
        set_b = 0; rst_b = 0;
        repeat (10) tick;

        // Reset during the second cycle of a four-cycle set pulse.
        set_c = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c >= 6) chk($sformatf("midpulse_pre_c%0d", c), out_c[4], {4'b0, (c >= 7)});
        end
        #2 rst_n = 1'b0;
        #1 chk("midpulse_async_clear", out_c, 5'b00000);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            logic [4:0] e;
            tick;
            e[4] = (c >= 7 && c <= 10);
            e[3] = 1'b0;
            e[2] = (c >= 7 && c <= 11);
            e[1] = 1'b0;
            e[0] = (c >= 7);
            chk($sformatf("after_reset_c%0d", c), out_c, e);
        end
        set_c = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
